// File: rtl/oven_pkg.sv
// Shared constants for the oven controller: key indices, key count and 50 MHz timing defaults.
package oven_pkg;

   localparam int N_KEYS = 6;

   localparam int KEY_PWR  = 0;
   localparam int KEY_BAKE = 1;
   localparam int KEY_RUN  = 2;
   localparam int KEY_DN   = 3;
   localparam int KEY_UP   = 4;
   localparam int KEY_SHOW = 5;

   localparam int DB_CYC_DEF        = 500_000;     // 10 ms
   localparam int RPT_DELAY_CYC_DEF = 25_000_000;  // 500 ms
   localparam int RPT_RATE_CYC_DEF  = 5_000_000;   // 100 ms
   localparam logic [N_KEYS-1:0] RPT_MASK_DEF = 6'b011000;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_e;

endpackage

// File: rtl/key_debounce.sv
// One key line: 2-flop synchronizer, stable-count debouncer and registered edge pulses.
module key_debounce #(
   parameter int DB_CYC = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic rise_now_o,
   output logic fall_now_o
);
   localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   always_comb begin
      sync_d  = {sync_q[0], raw_i};
      cnt_d   = '0;
      level_d = level_q;
      // Any cycle that agrees with the accepted level restarts the stability count.
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_LAST) level_d = sync_q[1];
         else                   cnt_d   = cnt_q + 1'b1;
      end
      rise_d = level_d & ~level_q;
      fall_d = ~level_d & level_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o    = level_q;
   assign rise_o     = rise_q;
   assign fall_o     = fall_q;
   assign rise_now_o = rise_d;
   assign fall_now_o = fall_d;

endmodule

// File: rtl/oven_key_conditioner.sv
// Oven key front-end: per-key debounce plus press/release pulses and auto-repeat on masked keys.
module oven_key_conditioner #(
   parameter int                N_KEYS        = oven_pkg::N_KEYS,
   parameter int                DB_CYC        = oven_pkg::DB_CYC_DEF,
   parameter int                RPT_DELAY_CYC = oven_pkg::RPT_DELAY_CYC_DEF,
   parameter int                RPT_RATE_CYC  = oven_pkg::RPT_RATE_CYC_DEF,
   parameter logic [N_KEYS-1:0] RPT_MASK      = N_KEYS'(oven_pkg::RPT_MASK_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_held
);
   import oven_pkg::*;

   localparam int TMAX = (RPT_DELAY_CYC > RPT_RATE_CYC) ? RPT_DELAY_CYC : RPT_RATE_CYC;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] DLY_LAST  = TW'(RPT_DELAY_CYC - 1);
   localparam logic [TW-1:0] RATE_LAST = TW'(RPT_RATE_CYC - 1);

   logic [N_KEYS-1:0] rise, rise_now, fall_now;

   for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
      localparam logic RPT_EN = RPT_MASK[gi];

      rpt_state_e    st_q, st_d;
      logic [TW-1:0] tmr_q, tmr_d;
      logic          rpt_q, rpt_d;
      logic          held_q, held_d;

      key_debounce #(.DB_CYC(DB_CYC)) u_deb (
         .clk        (clk),
         .rst        (rst),
         .raw_i      (key_raw[gi]),
         .level_o    (key_level[gi]),
         .rise_o     (rise[gi]),
         .fall_o     (key_release[gi]),
         .rise_now_o (rise_now[gi]),
         .fall_now_o (fall_now[gi])
      );

      // Reacting to the same-edge rise/fall keeps repeat timing aligned with the
      // press pulse and lets a release suppress a coincident repeat.
      always_comb begin
         st_d  = st_q;
         tmr_d = tmr_q;
         rpt_d = 1'b0;
         unique case (st_q)
            RPT_IDLE: begin
               if (RPT_EN && rise_now[gi]) begin
                  st_d  = RPT_DELAY;
                  tmr_d = '0;
               end
            end
            RPT_DELAY: begin
               if (fall_now[gi]) begin
                  st_d  = RPT_IDLE;
                  tmr_d = '0;
               end else if (tmr_q == DLY_LAST) begin
                  st_d  = RPT_REPEAT;
                  tmr_d = '0;
                  rpt_d = 1'b1;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
            RPT_REPEAT: begin
               if (fall_now[gi]) begin
                  st_d  = RPT_IDLE;
                  tmr_d = '0;
               end else if (tmr_q == RATE_LAST) begin
                  tmr_d = '0;
                  rpt_d = 1'b1;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
            default: begin
               st_d  = RPT_IDLE;
               tmr_d = '0;
            end
         endcase
         held_d = (st_d == RPT_REPEAT);
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            st_q   <= RPT_IDLE;
            tmr_q  <= '0;
            rpt_q  <= 1'b0;
            held_q <= 1'b0;
         end else begin
            st_q   <= st_d;
            tmr_q  <= tmr_d;
            rpt_q  <= rpt_d;
            held_q <= held_d;
         end
      end

      assign key_press[gi] = rise[gi] | rpt_q;
      assign key_held[gi]  = held_q;
   end

endmodule

// File: tb/tb_oven_key_conditioner.sv
// Scenario bench for oven_key_conditioner; pulse events are scoreboarded by cycle number.
module tb_oven_key_conditioner;
   localparam int NK   = 6;
   localparam int DB   = 4;
   localparam int DLY  = 20;
   localparam int RATE = 8;
   localparam int LAT  = DB + 2;   // drive negedge -> observed pulse, in cycles

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NK-1:0] key_raw = '0;
   logic [NK-1:0] key_level, key_press, key_release, key_held;

   int cyc = 0;
   int checks = 0;
   int passed = 0;

   typedef struct {
      int            cyc;
      logic [NK-1:0] p;
      logic [NK-1:0] r;
   } ev_t;
   ev_t sbq[$];
   ev_t mon_e;

   oven_key_conditioner #(
      .N_KEYS(NK), .DB_CYC(DB), .RPT_DELAY_CYC(DLY), .RPT_RATE_CYC(RATE),
      .RPT_MASK(6'b011000)
   ) dut (
      .clk(clk), .rst(rst), .key_raw(key_raw),
      .key_level(key_level), .key_press(key_press),
      .key_release(key_release), .key_held(key_held)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Every observed pulse cycle must match the next expected event exactly.
   always @(negedge clk) begin
      if ((key_press | key_release) != '0) begin
         checks++;
         if (sbq.size() == 0) begin
            $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b, none expected",
                     cyc, key_press, key_release);
         end else begin
            mon_e = sbq.pop_front();
            if (mon_e.cyc !== cyc || mon_e.p !== key_press || mon_e.r !== key_release)
               $display("FAIL pulse_event got cyc=%0d press=%b release=%b, expected cyc=%0d press=%b release=%b",
                        cyc, key_press, key_release, mon_e.cyc, mon_e.p, mon_e.r);
            else passed++;
         end
      end
   end

   task automatic push(input int c, input logic [NK-1:0] p, input logic [NK-1:0] r);
      ev_t e;
      e.cyc = c; e.p = p; e.r = r;
      sbq.push_back(e);
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      key_raw = '1;
      repeat (8) @(negedge clk);
      checks++;
      if (key_level !== '0 || key_press !== '0 || key_release !== '0 || key_held !== '0)
         $display("FAIL reset_outputs level=%b press=%b release=%b held=%b, expected all 0",
                  key_level, key_press, key_release, key_held);
      else passed++;
      key_raw = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (key_level !== '0) $display("FAIL reset_idle level=%b expected 0", key_level);
      else passed++;
   endtask

   task automatic test_clean_press();
      int c;
      @(negedge clk);
      c = cyc;
      key_raw[0] = 1'b1;
      push(c + LAT, 6'b000001, 6'b000000);
      wait_until(c + LAT - 1);
      checks++;
      if (key_level[0] !== 1'b0) $display("FAIL press_early level0=%b expected 0", key_level[0]);
      else passed++;
      wait_until(c + LAT);
      checks++;
      if (key_level[0] !== 1'b1) $display("FAIL press_level level0=%b expected 1", key_level[0]);
      else passed++;
      wait_until(c + LAT + 40);   // unmasked: no repeats allowed
      c = cyc;
      key_raw[0] = 1'b0;
      push(c + LAT, 6'b000000, 6'b000001);
      wait_until(c + LAT + 5);
      checks++;
      if (key_level[0] !== 1'b0 || sbq.size() != 0) begin
         $display("FAIL clean_release level0=%b pending=%0d, expected 0 and 0", key_level[0], sbq.size());
         sbq.delete();
      end else passed++;
   endtask

   task automatic test_glitch();
      int c;
      @(negedge clk);
      c = cyc;
      key_raw[2] = 1'b1;
      repeat (3) @(negedge clk);
      key_raw[2] = 1'b0;
      wait_until(c + 20);
      checks++;
      if (key_level[2] !== 1'b0) $display("FAIL glitch_level level2=%b expected 0", key_level[2]);
      else passed++;
   endtask

   task automatic test_hold();
      int c, p;
      @(negedge clk);
      c = cyc;
      p = c + LAT;
      key_raw[4] = 1'b1;
      push(p, 6'b010000, 6'b000000);
      for (int k = 0; k < 6; k++) push(p + DLY + k * RATE, 6'b010000, 6'b000000);
      wait_until(p + DLY - 1);
      checks++;
      if (key_held[4] !== 1'b0) $display("FAIL hold_held_early held4=%b expected 0", key_held[4]);
      else passed++;
      wait_until(p + DLY);
      checks++;
      if (key_held[4] !== 1'b1) $display("FAIL hold_held_on held4=%b expected 1", key_held[4]);
      else passed++;
      wait_until(p + 60);
      key_raw[4] = 1'b0;
      push(p + 60 + LAT, 6'b000000, 6'b010000);
      wait_until(p + 60 + LAT);
      checks++;
      if (key_held[4] !== 1'b0 || key_level[4] !== 1'b0)
         $display("FAIL hold_release held4=%b level4=%b expected 0 0", key_held[4], key_level[4]);
      else passed++;
      wait_until(p + 60 + LAT + 30);
      checks++;
      if (sbq.size() != 0) begin
         $display("FAIL hold_drain pending=%0d expected 0", sbq.size());
         sbq.delete();
      end else passed++;
   endtask

   task automatic test_release_on_expiry();
      int c, p;
      @(negedge clk);
      c = cyc;
      p = c + LAT;
      key_raw[3] = 1'b1;
      push(p, 6'b001000, 6'b000000);
      push(p + DLY, 6'b001000, 6'b000000);
      // Level falls on the edge where the second repeat would fire.
      wait_until(p + DLY + RATE - LAT);
      key_raw[3] = 1'b0;
      push(p + DLY + RATE, 6'b000000, 6'b001000);
      wait_until(p + DLY + RATE);
      checks++;
      if (key_release[3] !== 1'b1 || key_press[3] !== 1'b0)
         $display("FAIL expiry_release release3=%b press3=%b expected 1 0", key_release[3], key_press[3]);
      else passed++;
      wait_until(p + DLY + RATE + 1);
      checks++;
      if (key_held[3] !== 1'b0) $display("FAIL expiry_held held3=%b expected 0", key_held[3]);
      else passed++;
      wait_until(p + DLY + 4 * RATE);
      checks++;
      if (sbq.size() != 0) begin
         $display("FAIL expiry_drain pending=%0d expected 0", sbq.size());
         sbq.delete();
      end else passed++;
   endtask

   task automatic test_reset_mid();
      int c, p, r;
      @(negedge clk);
      c = cyc;
      p = c + LAT;
      key_raw[4] = 1'b1;
      push(p, 6'b010000, 6'b000000);
      push(p + DLY, 6'b010000, 6'b000000);
      push(p + DLY + RATE, 6'b010000, 6'b000000);
      wait_until(p + DLY + RATE + 2);
      rst = 1'b1;
      #1;
      checks++;
      if (key_level !== '0 || key_press !== '0 || key_release !== '0 || key_held !== '0)
         $display("FAIL midreset_clear level=%b press=%b release=%b held=%b, expected all 0",
                  key_level, key_press, key_release, key_held);
      else passed++;
      repeat (2) @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin
         $display("FAIL midreset_pre pending=%0d expected 0", sbq.size());
         sbq.delete();
      end else passed++;
      r = cyc;
      rst = 1'b0;
      push(r + LAT, 6'b010000, 6'b000000);
      push(r + LAT + DLY, 6'b010000, 6'b000000);
      push(r + LAT + DLY + RATE, 6'b010000, 6'b000000);
      wait_until(r + LAT + DLY - 1);
      checks++;
      if (key_held[4] !== 1'b0) $display("FAIL midreset_delay held4=%b expected 0", key_held[4]);
      else passed++;
      wait_until(r + LAT + DLY + RATE + 2);
      key_raw[4] = 1'b0;
      push(cyc + LAT, 6'b000000, 6'b010000);
      wait_until(cyc + LAT + 20);
      checks++;
      if (sbq.size() != 0) begin
         $display("FAIL midreset_drain pending=%0d expected 0", sbq.size());
         sbq.delete();
      end else passed++;
   endtask

   task automatic test_back_to_back();
      int c, p;
      @(negedge clk);
      c = cyc;
      p = c + LAT;
      key_raw[4:3] = 2'b11;
      push(p, 6'b011000, 6'b000000);
      push(p + DLY, 6'b011000, 6'b000000);
      push(p + DLY + RATE, 6'b011000, 6'b000000);
      wait_until(p + DLY + 1);
      checks++;
      if (key_held[4:3] !== 2'b11) $display("FAIL dual_held held=%b expected 11", key_held[4:3]);
      else passed++;
      // Both fall on the edge of the third repeat, which must be suppressed on both.
      wait_until(p + DLY + 2 * RATE - LAT);
      key_raw[4:3] = 2'b00;
      push(p + DLY + 2 * RATE, 6'b000000, 6'b011000);
      wait_until(p + DLY + 2 * RATE + 30);
      checks++;
      if (sbq.size() != 0 || key_level !== '0) begin
         $display("FAIL dual_drain pending=%0d level=%b expected 0 and 0", sbq.size(), key_level);
         sbq.delete();
      end else passed++;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_glitch();
      test_hold();
      test_release_on_expiry();
      test_reset_mid();
      test_back_to_back();
      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d limit reached", cyc);
      $display("%0d/%0d checks passed", passed, checks + 1);
      $fatal(1);
   end

endmodule
